// File: rtl/noc_link_axis_rx.sv
// -----------------------------------------------------------------------------
// noc_link_axis_rx
// Receive end of a credit-based router flit link. Incoming flits are buffered
// in a small FIFO and SERIALIZATION_FACTOR flits are gathered into one
// AXI-Stream beat. Every flit leaving the FIFO returns one credit upstream.
//
// Ports
//   clk_noc          single clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   data_in          flit payload (FLIT_WIDTH)
//   dest_in          flit destination {tid, tdest}
//   is_tail_in       last flit of a packet
//   send_in          flit valid this cycle (credit governed, no backpressure)
//   credit_out       one-cycle pulse per flit drained from the FIFO
//   axis_out_*       AXI-Stream master (tvalid/tready/tdata/tlast/tid/tdest)
//   overflow_err     sticky: a flit arrived while the FIFO was full
//   pkt_count        number of tail beats delivered
//
// Optional feature macro: RX_PKT_COUNT_EN
//   defined   -> pkt_count counts tvalid&tready&tlast handshakes (16-bit wrap)
//   undefined -> pkt_count is tied to zero and no counter exists
// -----------------------------------------------------------------------------
module noc_link_axis_rx #(
    parameter int FLIT_BUFFER_DEPTH    = 4,
    parameter int TDATA_WIDTH          = 128,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH
) (
    input  logic                   clk_noc,
    input  logic                   rst_n,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   overflow_err,
    output logic [15:0]            pkt_count
);

    localparam int SF      = SERIALIZATION_FACTOR;
    localparam int PTR_W   = $clog2(FLIT_BUFFER_DEPTH);
    localparam int IDX_W   = (SF > 1) ? $clog2(SF) : 1;
    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0]     mem_r [FLIT_BUFFER_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W:0]         count_r;

    // Beat assembly state
    logic [IDX_W-1:0]       idx_r;
    logic [TDATA_WIDTH-1:0] part_data_r;
    logic [TID_WIDTH-1:0]   part_tid_r;
    logic [TDEST_WIDTH-1:0] part_tdest_r;

    // Output register
    logic                   tvalid_r;
    logic [TDATA_WIDTH-1:0] tdata_r;
    logic                   tlast_r;
    logic [TID_WIDTH-1:0]   tid_r;
    logic [TDEST_WIDTH-1:0] tdest_r;
    logic                   credit_r;
    logic                   overflow_r;

    logic                   full_s;
    logic                   empty_s;
    logic                   wr_en_s;
    logic [ENTRY_W-1:0]     head_s;
    logic [FLIT_WIDTH-1:0]  head_data_s;
    logic [DEST_WIDTH-1:0]  head_dest_s;
    logic                   head_tail_s;
    logic                   last_sub_s;
    logic                   out_free_s;
    logic                   pop_s;
    logic                   load_s;
    logic [TDATA_WIDTH-1:0] placed_s;
    logic [TID_WIDTH-1:0]   first_tid_s;
    logic [TDEST_WIDTH-1:0] first_tdest_s;

    // Full is judged on the current occupancy, so a same-cycle pop never makes room.
    assign full_s  = (count_r == (PTR_W+1)'(FLIT_BUFFER_DEPTH));
    assign empty_s = (count_r == {(PTR_W+1){1'b0}});
    assign wr_en_s = send_in && !full_s;

    assign head_s      = mem_r[rd_ptr_r];
    assign head_data_s = head_s[FLIT_WIDTH-1:0];
    assign head_dest_s = head_s[FLIT_WIDTH +: DEST_WIDTH];
    assign head_tail_s = head_s[ENTRY_W-1];

    // A flit that closes the beat (last sub-flit or an early tail) needs the
    // output register; intermediate sub-flits only go into the partial beat.
    // Gating early tails on the output register keeps a held beat from being
    // overwritten.
    assign last_sub_s = (idx_r == IDX_W'(SF - 1)) || head_tail_s;
    assign out_free_s = !tvalid_r || axis_out_tready;
    assign pop_s      = !empty_s && (!last_sub_s || out_free_s);
    assign load_s     = pop_s && last_sub_s;

    // Position the head flit at its sub-flit slot and pick the beat's tid/tdest.
    always_comb begin
        placed_s = {TDATA_WIDTH{1'b0}};
        placed_s[idx_r*FLIT_WIDTH +: FLIT_WIDTH] = head_data_s;
        if (idx_r == {IDX_W{1'b0}}) begin
            first_tid_s   = head_dest_s[DEST_WIDTH-1 -: TID_WIDTH];
            first_tdest_s = head_dest_s[TDEST_WIDTH-1:0];
        end else begin
            first_tid_s   = part_tid_r;
            first_tdest_s = part_tdest_r;
        end
    end

    // FIFO payload storage (data only, no reset needed).
    always_ff @(posedge clk_noc) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {is_tail_in, dest_in, data_in};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Partial beat accumulation; cleared whenever a beat is handed to the output.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            idx_r        <= {IDX_W{1'b0}};
            part_data_r  <= {TDATA_WIDTH{1'b0}};
            part_tid_r   <= {TID_WIDTH{1'b0}};
            part_tdest_r <= {TDEST_WIDTH{1'b0}};
        end else if (load_s) begin
            idx_r       <= {IDX_W{1'b0}};
            part_data_r <= {TDATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            idx_r        <= idx_r + IDX_W'(1);
            part_data_r  <= part_data_r | placed_s;
            part_tid_r   <= first_tid_s;
            part_tdest_r <= first_tdest_s;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Output register: load a completed beat, drop tvalid after a handshake.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_r <= 1'b0;
            tdata_r  <= {TDATA_WIDTH{1'b0}};
            tlast_r  <= 1'b0;
            tid_r    <= {TID_WIDTH{1'b0}};
            tdest_r  <= {TDEST_WIDTH{1'b0}};
        end else if (load_s) begin
            tvalid_r <= 1'b1;
            tdata_r  <= part_data_r | placed_s;
            tlast_r  <= head_tail_s;
            tid_r    <= first_tid_s;
            tdest_r  <= first_tdest_s;
        end else if (tvalid_r && axis_out_tready) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

    // Credit return pulse and sticky overflow flag.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            credit_r   <= pop_s;
            overflow_r <= overflow_r || (send_in && full_s);
        end
    end

`ifdef RX_PKT_COUNT_EN
    logic [15:0] pkt_count_r;

    // Count delivered tail beats; wraps naturally at 16 bits.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_r <= 16'h0000;
        end else if (tvalid_r && axis_out_tready && tlast_r) begin
            pkt_count_r <= pkt_count_r + 16'h0001;
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    assign pkt_count = pkt_count_r;
`else
    assign pkt_count = 16'h0000;
`endif

    assign credit_out      = credit_r;
    assign overflow_err    = overflow_r;
    assign axis_out_tvalid = tvalid_r;
    assign axis_out_tdata  = tdata_r;
    assign axis_out_tlast  = tlast_r;
    assign axis_out_tid    = tid_r;
    assign axis_out_tdest  = tdest_r;

endmodule

// File: tb/tb_noc_link_axis_rx.sv
// -----------------------------------------------------------------------------
// tb_noc_link_axis_rx
// Two instances: dut_a (SF=1, 128-bit flits) and dut_b (SF=4, 32-bit flits),
// both with a 4-entry flit buffer. Expected beats come from a packet-level
// model: each accepted flit is appended to a pending list and a beat is cut
// when the list reaches SF flits or a tail arrives.
// -----------------------------------------------------------------------------
module tb_noc_link_axis_rx;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [127:0] d;
        logic         last;
        logic [1:0]   tid;
        logic [3:0]   tdest;
    } beat_t;

    typedef struct packed {
        logic        tail;
        logic [5:0]  dest;
        logic [31:0] data;
    } bflit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- dut_a signals ----------------
    logic         a_rst_n, a_tail, a_send, a_credit, a_tvalid, a_tready, a_tlast, a_ovf;
    logic [127:0] a_data, a_tdata;
    logic [5:0]   a_dest;
    logic [1:0]   a_tid;
    logic [3:0]   a_tdest;
    logic [15:0]  a_pkt;

    // ---------------- dut_b signals ----------------
    logic         b_rst_n, b_tail, b_send, b_credit, b_tvalid, b_tready, b_tlast, b_ovf;
    logic [31:0]  b_data;
    logic [127:0] b_tdata;
    logic [5:0]   b_dest;
    logic [1:0]   b_tid;
    logic [3:0]   b_tdest;
    logic [15:0]  b_pkt;

    noc_link_axis_rx #(.FLIT_BUFFER_DEPTH(DEPTH), .TDATA_WIDTH(128), .SERIALIZATION_FACTOR(1),
                       .TID_WIDTH(2), .TDEST_WIDTH(4)) dut_a (
        .clk_noc(clk), .rst_n(a_rst_n), .data_in(a_data), .dest_in(a_dest),
        .is_tail_in(a_tail), .send_in(a_send), .credit_out(a_credit),
        .axis_out_tvalid(a_tvalid), .axis_out_tready(a_tready), .axis_out_tdata(a_tdata),
        .axis_out_tlast(a_tlast), .axis_out_tid(a_tid), .axis_out_tdest(a_tdest),
        .overflow_err(a_ovf), .pkt_count(a_pkt));

    noc_link_axis_rx #(.FLIT_BUFFER_DEPTH(DEPTH), .TDATA_WIDTH(128), .SERIALIZATION_FACTOR(4),
                       .TID_WIDTH(2), .TDEST_WIDTH(4)) dut_b (
        .clk_noc(clk), .rst_n(b_rst_n), .data_in(b_data), .dest_in(b_dest),
        .is_tail_in(b_tail), .send_in(b_send), .credit_out(b_credit),
        .axis_out_tvalid(b_tvalid), .axis_out_tready(b_tready), .axis_out_tdata(b_tdata),
        .axis_out_tlast(b_tlast), .axis_out_tid(b_tid), .axis_out_tdest(b_tdest),
        .overflow_err(b_ovf), .pkt_count(b_pkt));

    // ---------------- reference model state ----------------
    beat_t  a_exp[$];
    beat_t  b_exp[$];
    bflit_t b_pend[$];
    int a_acc = 0, a_cred = 0, a_tail_hs = 0;
    int b_acc = 0, b_cred = 0, b_tail_hs = 0;
    beat_t a_hold, b_hold;
    bit a_hold_v = 1'b0, b_hold_v = 1'b0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pkt_exp(input int n);
`ifdef RX_PKT_COUNT_EN
        return n % 65536;
`else
        return 0;
`endif
    endfunction

    function automatic beat_t a_beat(input logic [127:0] d, input logic [5:0] ds, input logic tl);
        beat_t bt;
        bt.d = d; bt.last = tl; bt.tid = ds[5:4]; bt.tdest = ds[3:0];
        return bt;
    endfunction

    // Packet-level model for the SF=4 instance.
    task automatic b_model(input bflit_t f);
        beat_t bt;
        b_pend.push_back(f);
        if (f.tail || b_pend.size() == 4) begin
            bt.d = 128'h0;
            for (int j = 0; j < b_pend.size(); j++) bt.d[j*32 +: 32] = b_pend[j].data;
            bt.tid   = b_pend[0].dest[5:4];
            bt.tdest = b_pend[0].dest[3:0];
            bt.last  = f.tail;
            b_exp.push_back(bt);
            b_pend.delete();
        end
    endtask

    // Monitor for dut_a: credits, hold stability, beat content.
    always @(negedge clk) begin
        beat_t cur;
        if (!a_rst_n) begin
            a_hold_v = 1'b0;
        end else begin
            cur = {a_tdata, a_tlast, a_tid, a_tdest};
            if (a_credit) a_cred++;
            if (a_hold_v) begin
                chk("a_hold_tvalid", 160'(a_tvalid), 160'(1'b1));
                chk("a_hold_beat", 160'(cur), 160'(a_hold));
            end
            if (a_tvalid && a_tready) begin
                a_hold_v = 1'b0;
                if (a_tlast) a_tail_hs++;
                n_checks++;
                assert (a_exp.size() != 0) else begin
                    n_errors++;
                    $error("FAIL a_beat_unexpected: observed=%0h expected=none", cur);
                end
                if (a_exp.size() != 0) chk("a_beat", 160'(cur), 160'(a_exp.pop_front()));
            end else if (a_tvalid) begin
                a_hold = cur; a_hold_v = 1'b1;
            end
        end
    end

    // Monitor for dut_b: credits, hold stability, beat content.
    always @(negedge clk) begin
        beat_t cur;
        if (!b_rst_n) begin
            b_hold_v = 1'b0;
        end else begin
            cur = {b_tdata, b_tlast, b_tid, b_tdest};
            if (b_credit) b_cred++;
            if (b_hold_v) begin
                chk("b_hold_tvalid", 160'(b_tvalid), 160'(1'b1));
                chk("b_hold_beat", 160'(cur), 160'(b_hold));
            end
            if (b_tvalid && b_tready) begin
                b_hold_v = 1'b0;
                if (b_tlast) b_tail_hs++;
                n_checks++;
                assert (b_exp.size() != 0) else begin
                    n_errors++;
                    $error("FAIL b_beat_unexpected: observed=%0h expected=none", cur);
                end
                if (b_exp.size() != 0) chk("b_beat", 160'(cur), 160'(b_exp.pop_front()));
            end else if (b_tvalid) begin
                b_hold = cur; b_hold_v = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic a_put(input logic [127:0] d, input logic [5:0] ds, input logic tl, input bit acc);
        a_data = d; a_dest = ds; a_tail = tl; a_send = 1'b1;
        if (acc) begin a_exp.push_back(a_beat(d, ds, tl)); a_acc++; end
        tick();
        a_send = 1'b0;
    endtask

    task automatic b_put(input logic [31:0] d, input logic [5:0] ds, input logic tl);
        b_data = d; b_dest = ds; b_tail = tl; b_send = 1'b1;
        b_model({tl, ds, d}); b_acc++;
        tick();
        b_send = 1'b0;
    endtask

    task automatic a_drain();
        for (int k = 0; k < 200 && a_exp.size() != 0; k++) tick();
        repeat (3) tick();
        chk("a_drained", 160'(a_exp.size()), 160'(0));
    endtask

    task automatic b_drain();
        for (int k = 0; k < 200 && b_exp.size() != 0; k++) tick();
        repeat (3) tick();
        chk("b_drained", 160'(b_exp.size()), 160'(0));
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_tvalid"}, 160'(a_tvalid), 160'(1'b0));
        chk({tag, "_tdata"},  160'(a_tdata),  160'(128'h0));
        chk({tag, "_tlast"},  160'(a_tlast),  160'(1'b0));
        chk({tag, "_tid"},    160'(a_tid),    160'(2'b00));
        chk({tag, "_tdest"},  160'(a_tdest),  160'(4'h0));
        chk({tag, "_credit"}, 160'(a_credit), 160'(1'b0));
        chk({tag, "_ovf"},    160'(a_ovf),    160'(1'b0));
        chk({tag, "_pkt"},    160'(a_pkt),    160'(16'h0));
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_tvalid"}, 160'(b_tvalid), 160'(1'b0));
        chk({tag, "_tdata"},  160'(b_tdata),  160'(128'h0));
        chk({tag, "_tlast"},  160'(b_tlast),  160'(1'b0));
        chk({tag, "_tid"},    160'(b_tid),    160'(2'b00));
        chk({tag, "_tdest"},  160'(b_tdest),  160'(4'h0));
        chk({tag, "_credit"}, 160'(b_credit), 160'(1'b0));
        chk({tag, "_ovf"},    160'(b_ovf),    160'(1'b0));
        chk({tag, "_pkt"},    160'(b_pkt),    160'(16'h0));
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int sent;
        int cyc;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_data = 128'h0; a_dest = 6'h0; a_tail = 1'b0; a_send = 1'b0; a_tready = 1'b0;
        b_data = 32'h0;  b_dest = 6'h0; b_tail = 1'b0; b_send = 1'b0; b_tready = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_a("a_reset");
        chk_zero_b("b_reset");
        @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1; a_tready = 1'b1; b_tready = 1'b1;
        repeat (2) tick();

        // ---- SF=1 single flit latency ----
        a_data = {16{8'hA5}}; a_dest = 6'b10_0011; a_tail = 1'b1; a_send = 1'b1;
        a_exp.push_back(a_beat({16{8'hA5}}, 6'b10_0011, 1'b1)); a_acc++;
        @(negedge clk);
        chk("lat_tvalid_t", 160'(a_tvalid), 160'(1'b0));
        tick();
        a_send = 1'b0;
        @(negedge clk);
        chk("lat_tvalid_t1", 160'(a_tvalid), 160'(1'b0));
        chk("lat_credit_t1", 160'(a_credit), 160'(1'b0));
        @(negedge clk);
        chk("lat_tvalid_t2", 160'(a_tvalid), 160'(1'b1));
        chk("lat_credit_t2", 160'(a_credit), 160'(1'b1));
        chk("lat_tid",   160'(a_tid),   160'(2'd2));
        chk("lat_tdest", 160'(a_tdest), 160'(4'd3));
        chk("lat_tlast", 160'(a_tlast), 160'(1'b1));
        chk("lat_tdata", 160'(a_tdata), 160'({16{8'hA5}}));
        @(negedge clk);
        chk("lat_credit_t3", 160'(a_credit), 160'(1'b0));
        chk("lat_tvalid_t3", 160'(a_tvalid), 160'(1'b0));
        tick();

        // ---- backpressure and overflow ----
        a_tready = 1'b0;
        c0 = a_cred;
        for (int i = 0; i < 4; i++)
            a_put({4{$urandom}}, 6'($urandom_range(0, 63)), 1'b1, 1'b1);
        repeat (4) tick();
        chk("bp_credits_held", 160'(a_cred - c0), 160'(1));
        chk("bp_tvalid", 160'(a_tvalid), 160'(1'b1));
        chk("bp_no_ovf", 160'(a_ovf), 160'(1'b0));
        a_put(128'h5555, 6'h15, 1'b1, 1'b1);
        repeat (2) tick();
        a_put(128'h6666, 6'h26, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_ovf_set", 160'(a_ovf), 160'(1'b1));
        tick();
        a_tready = 1'b1;
        a_drain();
        chk("bp_credits_total", 160'(a_cred - c0), 160'(5));
        chk("bp_ovf_sticky", 160'(a_ovf), 160'(1'b1));
        chk("bp_pkt", 160'(a_pkt), 160'(pkt_exp(a_tail_hs)));

        // ---- reset dut_a, then random traffic ----
        a_rst_n = 1'b0;
        repeat (2) tick();
        a_cred = 0; a_acc = 0; a_tail_hs = 0; a_exp.delete();
        a_rst_n = 1'b1;
        tick();
        chk("a_ovf_cleared", 160'(a_ovf), 160'(1'b0));
        sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            a_tready = ($urandom_range(0, 3) != 0);
            if ((a_acc - a_cred) < DEPTH && $urandom_range(0, 4) != 0) begin
                a_data = {$urandom, $urandom, $urandom, $urandom};
                a_dest = 6'($urandom_range(0, 63));
                a_tail = ($urandom_range(0, 3) == 0);
                a_send = 1'b1;
                a_exp.push_back(a_beat(a_data, a_dest, a_tail));
                a_acc++; sent++;
            end else begin
                a_send = 1'b0;
            end
            tick();
            cyc++;
        end
        a_send = 1'b0; a_tready = 1'b1;
        chk("a_rand_sent", 160'(sent), 160'(10000));
        a_drain();
        chk("a_rand_credits", 160'(a_cred), 160'(a_acc));
        chk("a_rand_no_ovf", 160'(a_ovf), 160'(1'b0));
        chk("a_rand_pkt", 160'(a_pkt), 160'(pkt_exp(a_tail_hs)));

        // ---- SF=4 directed assembly ----
        b_put(32'h1111_1111, 6'b01_1010, 1'b0);
        b_put(32'h2222_2222, 6'b11_1111, 1'b0);
        b_put(32'h3333_3333, 6'b00_0001, 1'b0);
        b_put(32'h4444_4444, 6'b10_0110, 1'b1);
        b_put(32'h0000_00AA, 6'b11_0101, 1'b0);
        b_put(32'h0000_00BB, 6'b00_0000, 1'b1);
        b_put(32'h0000_00CC, 6'b01_0111, 1'b0);
        b_put(32'h0000_00DD, 6'b00_0000, 1'b0);
        b_put(32'h0000_00EE, 6'b00_0000, 1'b0);
        b_put(32'h0000_00FF, 6'b00_0000, 1'b0);
        b_put(32'h0000_0099, 6'b10_1000, 1'b1);
        b_drain();
        chk("b_dir_credits", 160'(b_cred), 160'(b_acc));

        // ---- reset mid-beat on dut_b ----
        b_tready = 1'b0;
        c0 = b_cred;
        b_put(32'h0000_0001, 6'b01_0001, 1'b0);
        b_put(32'h0000_0002, 6'b01_0001, 1'b0);
        b_put(32'h0000_0003, 6'b01_0001, 1'b0);
        b_put(32'h0000_0004, 6'b01_0001, 1'b1);
        b_put(32'h0000_0055, 6'b10_0010, 1'b0);
        repeat (6) tick();
        @(negedge clk);
        chk("b_pre_rst_tvalid", 160'(b_tvalid), 160'(1'b1));
        chk("b_pre_rst_credits", 160'(b_cred - c0), 160'(5));
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        @(negedge clk);
        chk_zero_b("b_midrst");
        b_exp.delete(); b_pend.delete(); b_cred = 0; b_acc = 0; b_tail_hs = 0;
        @(posedge clk); #1;
        b_rst_n = 1'b1; b_tready = 1'b1;
        tick();
        b_put(32'h1234_5678, 6'b11_0110, 1'b0);
        b_put(32'h9ABC_DEF0, 6'b00_0000, 1'b1);
        b_drain();
        chk("b_post_rst_credits", 160'(b_cred), 160'(2));
        chk("b_post_rst_pkt", 160'(b_pkt), 160'(pkt_exp(b_tail_hs)));

        // ---- SF=4 random traffic ----
        sent = 0; cyc = 0;
        while (sent < 2000 && cyc < 20000) begin
            b_tready = ($urandom_range(0, 3) != 0);
            if ((b_acc - b_cred) < DEPTH && $urandom_range(0, 4) != 0) begin
                b_data = $urandom;
                b_dest = 6'($urandom_range(0, 63));
                b_tail = ($urandom_range(0, 2) == 0);
                b_send = 1'b1;
                b_model({b_tail, b_dest, b_data});
                b_acc++; sent++;
            end else begin
                b_send = 1'b0;
            end
            tick();
            cyc++;
        end
        b_send = 1'b0; b_tready = 1'b1;
        chk("b_rand_sent", 160'(sent), 160'(2000));
        b_drain();
        chk("b_rand_credits", 160'(b_cred), 160'(b_acc));
        chk("b_rand_no_ovf", 160'(b_ovf), 160'(1'b0));
        chk("b_rand_pkt", 160'(b_pkt), 160'(pkt_exp(b_tail_hs)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
